// File: rtl/sap_pkg.sv
// Shared types for the SAP-1 controller: opcodes, T-state encoding and the control word.
// The optional single-step feature is enabled by defining SAP_STEP_EN.
package sap_pkg;

  localparam int T_W = 6;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  // Every field is active-high here; polarity is applied at the output pins.
  typedef struct packed {
    logic cp;
    logic ep;
    logic ea;
    logic su;
    logic eu;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic lb;
    logic lo;
  } ctrl_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T1..T6 ring; rotates on advance unless frozen, resets to T1.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           advance,
  input  logic           freeze,
  output logic [T_W-1:0] t_state
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_state <= T1;
    end else if (advance && !freeze) begin
      t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: ring counter plus combinational strobe decode.
// Define SAP_STEP_EN to add run_mode/step single-stepping.
module sap_controller
  import sap_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
`ifdef SAP_STEP_EN
  input  logic           run_mode,
  input  logic           step,
`endif
  input  logic [3:0]     opcode,
  output logic           cp,
  output logic           ep,
  output logic           ea,
  output logic           su,
  output logic           eu,
  output logic           lm_n,
  output logic           ce_n,
  output logic           li_n,
  output logic           ei_n,
  output logic           la_n,
  output logic           lb_n,
  output logic           lo_n,
  output logic           halted,
  output logic [T_W-1:0] t_state
);

  ctrl_t cw;
  logic  advance;
  logic  hlt_t4;
  logic  freeze;
  logic  active;

`ifdef SAP_STEP_EN
  logic step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // A held step produces a single advance on its rising edge.
  assign advance = run_mode | (step & ~step_q);
`else
  assign advance = 1'b1;
`endif

  assign hlt_t4 = (t_state == T4) && (opcode == OP_HLT);
  assign freeze = halted | hlt_t4;
  assign active = ~reset & ~halted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (hlt_t4 && advance) begin
      halted <= 1'b1;
    end
  end

  sap_ring_counter u_ring (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
    .freeze  (freeze),
    .t_state (t_state)
  );

  always_comb begin
    cw = '0;
    case (t_state)
      T1: begin
        cw.ep = 1'b1;
        cw.lm = 1'b1;
      end
      T2: cw.cp = 1'b1;
      T3: begin
        cw.ce = 1'b1;
        cw.li = 1'b1;
      end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw.ei = 1'b1;
            cw.lm = 1'b1;
          end
          OP_OUT: begin
            cw.ea = 1'b1;
            cw.lo = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            cw.ce = 1'b1;
            cw.la = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ce = 1'b1;
            cw.lb = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.eu = 1'b1;
          cw.la = 1'b1;
          cw.su = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Bus enables hold through a stall; the PC increment and register loads fire only on advance.
  assign ep   = active & cw.ep;
  assign ea   = active & cw.ea;
  assign su   = active & cw.su;
  assign eu   = active & cw.eu;
  assign ce_n = ~(active & cw.ce);
  assign ei_n = ~(active & cw.ei);
  assign cp   = active & advance & cw.cp;
  assign lm_n = ~(active & advance & cw.lm);
  assign li_n = ~(active & advance & cw.li);
  assign la_n = ~(active & advance & cw.la);
  assign lb_n = ~(active & advance & cw.lb);
  assign lo_n = ~(active & advance & cw.lo);

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: per-cycle expected state/strobes queued and compared.
module tb_sap_controller;

  logic       clock;
  logic       reset;
  logic [3:0] opcode;
  logic       cp, ep, ea, su, eu, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, halted;
  logic [5:0] t_state;
`ifdef SAP_STEP_EN
  logic       run_mode;
  logic       step;
`endif

  logic [11:0] dut_ctrl;
  assign dut_ctrl = {cp, ep, ea, su, eu, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n};

  localparam logic [11:0] IDLE = 12'b00000_1111111;

  typedef struct packed {
    logic [5:0]  t;
    logic        h;
    logic [11:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_t   = 0;
  bit   m_halt = 1'b0;

  sap_controller dut (
    .clock   (clock),
    .reset   (reset),
`ifdef SAP_STEP_EN
    .run_mode(run_mode),
    .step    (step),
`endif
    .opcode  (opcode),
    .cp      (cp),
    .ep      (ep),
    .ea      (ea),
    .su      (su),
    .eu      (eu),
    .lm_n    (lm_n),
    .ce_n    (ce_n),
    .li_n    (li_n),
    .ei_n    (ei_n),
    .la_n    (la_n),
    .lb_n    (lb_n),
    .lo_n    (lo_n),
    .halted  (halted),
    .t_state (t_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference strobes, ordered {cp,ep,ea,su,eu,lm_n,ce_n,li_n,ei_n,la_n,lb_n,lo_n}.
  function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op, input bit h);
    logic c_p, e_p, e_a, s_u, e_u, l_m, c_e, l_i, e_i, l_a, l_b, l_o;
    {c_p, e_p, e_a, s_u, e_u} = 5'b0;
    {l_m, c_e, l_i, e_i, l_a, l_b, l_o} = 7'b1111111;
    if (!h) begin
      if (t == 0) begin e_p = 1; l_m = 0; end
      if (t == 1) c_p = 1;
      if (t == 2) begin c_e = 0; l_i = 0; end
      if (t == 3 && op <= 4'h2) begin e_i = 0; l_m = 0; end
      if (t == 3 && op == 4'hE) begin e_a = 1; l_o = 0; end
      if (t == 4 && op == 4'h0) begin c_e = 0; l_a = 0; end
      if (t == 4 && (op == 4'h1 || op == 4'h2)) begin c_e = 0; l_b = 0; end
      if (t == 5 && (op == 4'h1 || op == 4'h2)) begin e_u = 1; l_a = 0; s_u = (op == 4'h2); end
    end
    return {c_p, e_p, e_a, s_u, e_u, l_m, c_e, l_i, e_i, l_a, l_b, l_o};
  endfunction

  task automatic run_cycle();
    exp_t e;
    exp_t g;
    e.t = 6'(1 << m_t);
    e.h = m_halt;
    e.c = exp_ctrl(m_t, opcode, m_halt);
    q.push_back(e);
    @(negedge clock);
    g = q.pop_front();
    chk("t_state", 32'(t_state), 32'(g.t));
    chk("halted", 32'(halted), 32'(g.h));
    chk("ctrl", 32'(dut_ctrl), 32'(g.c));
    @(posedge clock);
    if (!m_halt && m_t == 3 && opcode == 4'hF) m_halt = 1'b1;
    else if (!m_halt) m_t = (m_t + 1) % 6;
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op);
    opcode = op;
    repeat (6) run_cycle();
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 4'h0;
`ifdef SAP_STEP_EN
    run_mode = 1'b1;
    step     = 1'b0;
`endif
    @(negedge clock);
    chk("rst_t_state", 32'(t_state), 32'h01);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ctrl", 32'(dut_ctrl), 32'(IDLE));
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    m_t = 0;
    m_halt = 1'b0;

    run_instr(4'h0);
    run_instr(4'h2);
    run_instr(4'h1);
    run_instr(4'hE);
    run_instr(4'h7);
    run_instr(4'h0);

    opcode = 4'hF;
    repeat (25) run_cycle();

    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("hlt_rst_t_state", 32'(t_state), 32'h01);
    chk("hlt_rst_halted", 32'(halted), 32'h0);
    chk("hlt_rst_ctrl", 32'(dut_ctrl), 32'(IDLE));
    @(posedge clock);
    #1 reset = 1'b0;
    m_t = 0;
    m_halt = 1'b0;

    opcode = 4'h1;
    repeat (4) run_cycle();
    @(negedge clock);
    chk("add_t5_lb_n", 32'(lb_n), 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("abort_lb_n", 32'(lb_n), 32'h1);
    chk("abort_t_state", 32'(t_state), 32'h01);
    chk("abort_ctrl", 32'(dut_ctrl), 32'(IDLE));
    @(posedge clock);
    #1;
    chk("rst_hold_ctrl", 32'(dut_ctrl), 32'(IDLE));
    chk("rst_hold_t_state", 32'(t_state), 32'h01);
    reset = 1'b0;
    m_t = 0;
    run_instr(4'h1);

`ifdef SAP_STEP_EN
    begin
      int cp_cnt;
      opcode = 4'h0;
      run_cycle();
      run_mode = 1'b0;
      @(negedge clock);
      chk("stall_t_state", 32'(t_state), 32'h02);
      chk("stall_cp", 32'(cp), 32'h0);
      @(posedge clock);
      #1;
      chk("stall_hold", 32'(t_state), 32'h02);
      step = 1'b1;
      cp_cnt = 0;
      repeat (5) begin
        @(negedge clock);
        if (cp) cp_cnt++;
        @(posedge clock);
        #1;
      end
      chk("step_cp_count", 32'(cp_cnt), 32'h1);
      chk("step_t_state", 32'(t_state), 32'h04);
      @(negedge clock);
      chk("step_li_n", 32'(li_n), 32'h1);
      chk("step_ce_n", 32'(ce_n), 32'h0);
      step = 1'b0;
      run_mode = 1'b1;
    end
`endif

    if (q.size() != 0) chk("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
